// File: rtl/led_chain_pkg.sv
// Shared types and default sizing for the daisy-chained LED board transmitter.
package led_chain_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SHIFT_LO = 2'd1,
    SHIFT_HI = 2'd2,
    LATCH    = 2'd3
  } state_t;

  localparam int NUM_DEF     = 4;
  localparam int CLK_DIV_DEF = 4;

endpackage

// File: rtl/led_chain_tick.sv
// CLK_DIV prescaler: strobes tc on the last cycle of each CLK_DIV-cycle phase.
module led_chain_tick #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic tc
);

  localparam int CW = $clog2(CLK_DIV) + 1;
  localparam logic [CW-1:0] TERM = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt;

  // Saturates at TERM so an idle FSM never sees the count wrap.
  always_ff @(posedge clk) begin
    if (rst || restart) cnt <= '0;
    else if (cnt != TERM) cnt <= cnt + 1'b1;
  end

  assign tc = (cnt == TERM);

endmodule

// File: rtl/led_chain_tx.sv
// Serialises an NUM*8-bit LED frame MSB first into a chain of 595-style boards.
module led_chain_tx
  import led_chain_pkg::*;
#(
  parameter int NUM     = NUM_DEF,
  parameter int CLK_DIV = CLK_DIV_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NUM*8-1:0] led_all,
  input  logic             load,
  output logic             busy,
  output logic             done,
  output logic             ser_out,
  output logic             sr_clk,
  output logic             latch
);

  localparam int W  = NUM * 8;
  localparam int BW = $clog2(W) + 1;

  state_t         state, state_nx;
  logic           tc, restart, last_bit;
  logic [W-1:0]   shadow;
  logic [BW-1:0]  bit_idx;

  assign last_bit = (bit_idx == '0);
  assign restart  = (state_nx != state);

  led_chain_tick #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk     (clk),
    .rst     (rst),
    .restart (restart),
    .tc      (tc)
  );

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:     if (load) state_nx = SHIFT_LO;
      SHIFT_LO: if (tc)   state_nx = SHIFT_HI;
      SHIFT_HI: if (tc)   state_nx = last_bit ? LATCH : SHIFT_LO;
      LATCH:    if (tc)   state_nx = IDLE;
      default:            state_nx = IDLE;
    endcase
  end

  // Outputs decode the next state so they line up with the state they describe.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      shadow  <= '0;
      bit_idx <= '0;
      ser_out <= 1'b0;
      sr_clk  <= 1'b0;
      latch   <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state  <= state_nx;
      busy   <= (state_nx != IDLE);
      sr_clk <= (state_nx == SHIFT_HI);
      latch  <= (state_nx == LATCH);
      done   <= (state == LATCH) && (state_nx == IDLE);
      if (state == IDLE && load) begin
        shadow  <= led_all;
        bit_idx <= BW'(W - 1);
        ser_out <= led_all[W-1];
      end else if (state == SHIFT_HI && tc) begin
        // Data only moves after the boards have seen the sr_clk rise.
        if (last_bit) begin
          ser_out <= 1'b0;
        end else begin
          shadow  <= {shadow[W-2:0], 1'b0};
          bit_idx <= bit_idx - 1'b1;
          ser_out <= shadow[W-2];
        end
      end
    end
  end

endmodule

// File: tb/tb_led_chain_tx.sv
// Directed bench: default 4-board chain and a 1-board CLK_DIV=1 chain side by side.
module tb_led_chain_tx;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] led_a;
  logic [7:0]  led_b;
  logic        load_a, load_b;
  logic        busy_a, done_a, ser_a, src_a, lat_a;
  logic        busy_b, done_b, ser_b, src_b, lat_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  led_chain_tx dut_a (
    .clk(clk), .rst(rst), .led_all(led_a), .load(load_a),
    .busy(busy_a), .done(done_a), .ser_out(ser_a), .sr_clk(src_a), .latch(lat_a)
  );

  led_chain_tx #(.NUM(1), .CLK_DIV(1)) dut_b (
    .clk(clk), .rst(rst), .led_all(led_b), .load(load_b),
    .busy(busy_b), .done(done_b), .ser_out(ser_b), .sr_clk(src_b), .latch(lat_b)
  );

  typedef struct {
    bit          sel;
    logic [31:0] v;
    int          exp_done;
    int          exp_lf;
    int          exp_ll;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic rd(input bit s, output logic b, output logic sc, output logic sd,
                    output logic lt, output logic dn);
    if (s) begin b = busy_b; sc = src_b; sd = ser_b; lt = lat_b; dn = done_b; end
    else   begin b = busy_a; sc = src_a; sd = ser_a; lt = lat_a; dn = done_a; end
  endtask

  task automatic set_in(input bit s, input logic ld, input logic [31:0] v);
    if (s) begin load_b = ld; led_b = v[7:0]; end
    else   begin load_a = ld; led_a = v; end
  endtask

  // One frame: serial capture, 595 chain model, phase/timing checks.
  task automatic do_frame(input bit sel, input logic [31:0] v, input int exp_done,
                          input int exp_lf, input int exp_ll, input bit noise);
    int w  = sel ? 8 : 32;
    int cd = sel ? 1 : 4;
    logic [31:0] bits = '0, sr = '0, q = '0;
    int nbits = 0, lf = -1, ll = -1, dcyc = -1, ndone = 0, perr = 0, post = 0;
    logic psc = 1'b0, plt = 1'b0;
    logic b, sc, sd, lt, dn, exp_sc;
    @(negedge clk);
    set_in(sel, 1'b1, v);
    @(posedge clk);
    for (int c = 1; c <= 2000 && dcyc < 0; c++) begin
      @(negedge clk);
      if (noise && (c == 10 || c == 100)) set_in(sel, 1'b1, ~v);
      else set_in(sel, 1'b0, noise ? ~v : v);
      rd(sel, b, sc, sd, lt, dn);
      if (sc && !psc) begin bits = {bits[30:0], sd}; sr = {sr[30:0], sd}; nbits++; end
      if (lt && !plt) q = sr;
      if (lt) begin if (lf < 0) lf = c; ll = c; end
      if (dn) begin ndone++; dcyc = c; end
      if (c <= 2*cd*w) begin
        exp_sc = (((c - 1) / cd) % 2) != 0;
        if (sc !== exp_sc || b !== 1'b1 || lt !== 1'b0 || dn !== 1'b0) perr++;
      end else if (c <= 2*cd*w + cd) begin
        if (lt !== 1'b1 || sc !== 1'b0 || sd !== 1'b0 || b !== 1'b1) perr++;
      end else if (b !== 1'b0) perr++;
      psc = sc; plt = lt;
    end
    set_in(sel, 1'b0, v);
    repeat (3) begin
      @(negedge clk);
      rd(sel, b, sc, sd, lt, dn);
      if (b || dn || lt) post++;
    end
    chk("serial_bits", bits, v);
    chk("bit_count", nbits, w);
    chk("done_cycle", dcyc, exp_done);
    chk("latch_first", lf, exp_lf);
    chk("latch_last", ll, exp_ll);
    chk("phase_errs", perr, 0);
    chk("done_count", ndone, 1);
    chk("post_idle", post, 0);
    chk("hc595_out", q, v);
    if (v == 32'hA5C3_0FF0) begin
      chk("board3", q[31:24], 32'hA5);
      chk("board2", q[23:16], 32'hC3);
      chk("board1", q[15:8],  32'h0F);
      chk("board0", q[7:0],   32'hF0);
    end
  endtask

  vec_t vecs[7];
  int   dq[$];
  int   blow, nerr;

  initial begin
    vecs[0] = '{1'b0, 32'h0000_0001, 261, 257, 260};
    vecs[1] = '{1'b0, 32'hA5C3_0FF0, 261, 257, 260};
    vecs[2] = '{1'b0, 32'hFFFF_FFFF, 261, 257, 260};
    vecs[3] = '{1'b0, 32'h8000_0000, 261, 257, 260};
    vecs[4] = '{1'b0, 32'h0000_0000, 261, 257, 260};
    vecs[5] = '{1'b1, 32'h0000_0081, 18, 17, 17};
    vecs[6] = '{1'b1, 32'h0000_005A, 18, 17, 17};

    rst = 1'b1; load_a = 1'b1; load_b = 1'b1; led_a = '1; led_b = '1;
    repeat (3) @(negedge clk);
    chk("rst_a_outs", {busy_a, done_a, ser_a, src_a, lat_a}, 0);
    chk("rst_b_outs", {busy_b, done_b, ser_b, src_b, lat_b}, 0);
    load_a = 1'b0; load_b = 1'b0; rst = 1'b0;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 7; i++)
      do_frame(vecs[i].sel, vecs[i].v, vecs[i].exp_done, vecs[i].exp_lf, vecs[i].exp_ll, 1'b0);

    // Loads during a frame with new data must be ignored.
    do_frame(1'b0, 32'h0F0F_3C3C, 261, 257, 260, 1'b1);

    // load held high: back-to-back frames, busy low only in done cycles.
    @(negedge clk);
    led_a = 32'h1234_5678; load_a = 1'b1;
    @(posedge clk);
    blow = 0;
    for (int c = 1; c <= 800; c++) begin
      @(negedge clk);
      if (done_a) dq.push_back(c);
      if (!busy_a && !done_a) blow++;
    end
    load_a = 1'b0;
    chk("b2b_ndone", dq.size(), 3);
    chk("b2b_done0", dq.size() > 0 ? dq[0] : -1, 261);
    chk("b2b_done1", dq.size() > 1 ? dq[1] : -1, 522);
    chk("b2b_done2", dq.size() > 2 ? dq[2] : -1, 783);
    chk("b2b_busy_gap", blow, 0);
    nerr = 1;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if (!busy_a) begin nerr = 0; break; end
    end
    chk("b2b_drain", nerr, 0);
    repeat (2) @(negedge clk);

    // Reset mid-frame at cycle 50, with load asserted alongside it.
    @(negedge clk);
    led_a = 32'hFFFF_0000; load_a = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 50; c++) begin
      @(negedge clk);
      load_a = 1'b0;
    end
    rst = 1'b1; load_a = 1'b1;
    @(negedge clk);
    chk("midrst_outs", {busy_a, done_a, ser_a, src_a, lat_a}, 0);
    rst = 1'b0; load_a = 1'b0;
    nerr = 0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (busy_a || lat_a || done_a || src_a) nerr++;
    end
    chk("midrst_quiet", nerr, 0);
    do_frame(1'b0, 32'hDEAD_BEEF, 261, 257, 260, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/led_chain_tx.md
LED_CHAIN_TX -- requirements
Module: led_chain_tx

Interface
REQ-001 Parameter NUM, default 4: number of daisy-chained 8-LED boards; frame width W = NUM*8 bits.
REQ-002 Parameter CLK_DIV, default 4, legal range >= 1: clk cycles per sr_clk half-period.
REQ-003 clk  input  1  single system clock; all logic on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 led_all  input  W  parallel LED frame, bit W-1 = board NUM-1 LED 7, bit 0 = board 0 LED 0.
REQ-006 load  input  1  request to transmit led_all; sampled only in IDLE.
REQ-007 busy  output  1  high while a frame is shifting or latching.
REQ-008 done  output  1  one-cycle pulse at frame completion.
REQ-009 ser_out  output  1  serial data to first shift register in the chain.
REQ-010 sr_clk  output  1  shift clock to the chain; data captured by boards on its rising edge.
REQ-011 latch  output  1  storage-register latch to all boards; outputs update on its rising edge.

Function
REQ-012 FSM states: IDLE, SHIFT_LO, SHIFT_HI, LATCH; encoding per shared package.
REQ-013 IDLE with load=1 at edge of cycle 0: led_all captured into internal shadow register, bit index = W-1, next state SHIFT_LO.
REQ-014 Bits shifted MSB first (led_all[W-1] first, led_all[0] last), so after W bits board NUM-1 holds the top byte.
REQ-015 Bit i (i = 0..W-1, in transmission order): SHIFT_LO cycles 1+2*CLK_DIV*i .. CLK_DIV+2*CLK_DIV*i with sr_clk=0, then SHIFT_HI for CLK_DIV cycles with sr_clk=1.
REQ-016 ser_out holds the current bit for the whole SHIFT_LO+SHIFT_HI span of that bit; it changes only on SHIFT_HI->SHIFT_LO or SHIFT_HI->LATCH transitions.
REQ-017 After SHIFT_HI of the last bit: LATCH for CLK_DIV cycles, latch=1, sr_clk=0, ser_out=0.
REQ-018 LATCH exit -> IDLE; done=1 for exactly the first IDLE cycle (cycle 2*CLK_DIV*W+CLK_DIV+1); busy=0 in that cycle.
REQ-019 busy=1 from cycle 1 through the last LATCH cycle inclusive; total frame = 2*CLK_DIV*W + CLK_DIV + 1 cycles including the done cycle (261 for defaults).
REQ-020 load while busy=1 ignored; no queueing; led_all changes during a frame do not affect the frame in flight.
REQ-021 load=1 in the done cycle is accepted (back-to-back frames, no dead cycle beyond done).
REQ-022 Counters: divider counter width $clog2(CLK_DIV)+1, bit counter width $clog2(W)+1; no wrap past terminal values.
REQ-023 All outputs registered; no combinational path from load or led_all to any output.

Reset
REQ-024 rst=1 at a clock edge forces state IDLE, busy=0, done=0, ser_out=0, sr_clk=0, latch=0, counters and shadow cleared.
REQ-025 rst asserted mid-frame aborts the frame within one cycle; no latch pulse issued; load in the same cycle as rst ignored.
REQ-026 First load after rst deasserts is accepted normally.

Structure
REQ-027 Package led_chain_pkg holds the state typedef and default constants (NUM, CLK_DIV).
REQ-028 One sub-module, led_chain_tick: CLK_DIV prescaler emitting a one-cycle terminal-count strobe, restarted on state change.

Verification
REQ-029 Defaults, led_all=32'h0000_0001, load pulse -> 32 bits on ser_out sampled at sr_clk rises = 31 zeros then 1; latch high cycles 257-260; done at 261.
REQ-030 led_all=32'hA5C3_0FF0 via behavioural 4x74HC595 model -> board3..0 outputs 8'hA5, 8'hC3, 8'h0F, 8'hF0 after latch rise.
REQ-031 load re-asserted at cycles 10 and 100 with led_all changed -> ignored, frame data unchanged, single done.
REQ-032 load held high continuously -> frames back-to-back, done every 261 cycles, busy low only in done cycles.
REQ-033 rst at cycle 50 of a frame -> all outputs 0 next cycle, no latch pulse; new load then completes a full frame.
REQ-034 NUM=1, CLK_DIV=1, led_all=8'h81 -> frame length 18 cycles, sr_clk toggles every cycle, done at cycle 18.
